// File: rtl/dma_desc_ring_ctrl.sv
// dma_desc_ring_ctrl
// Descriptor ring controller for the packet-capture DMA path. It fetches
// 128-bit descriptors from a ring in host memory. For each descriptor that is
// marked available (empty flag = 1), it hands the buffer address to the DMA
// write engine and waits for the completed length. It then writes the
// descriptor back with the length filled in and the empty flag cleared, and
// advances around the ring.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   enable                      ring processing enable
//   ring_base_addr, ring_size   ring placement (16-byte aligned) and length (0 = off)
//   m_rd_*                      descriptor read request / single-beat response
//   m_wr_*                      descriptor writeback request
//   m_desc_*                    buffer address to the DMA write engine
//   s_cpl_*                     completion (bytes written) from the DMA write engine
//   ring_index                  current descriptor index
//   busy                        high whenever the FSM is not idle
//   state_dbg                   current FSM state encoding
//
// Handshake rule on every valid/ready pair: a transfer happens on a rising
// edge where valid and ready are both high. While valid is high and the
// transfer has not happened, the payload is held stable. The valid drops in
// the cycle after the transfer. m_rd_data_valid is a single-cycle strobe with
// no backpressure.
module dma_desc_ring_ctrl #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int LEN_WIDTH      = 16,
   parameter int INDEX_WIDTH    = 8,
   parameter int POLL_INTERVAL  = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [AXI_ADDR_WIDTH-1:0] ring_base_addr,
   input  logic [INDEX_WIDTH:0]      ring_size,
   output logic [AXI_ADDR_WIDTH-1:0] m_rd_addr,
   output logic                      m_rd_valid,
   input  logic                      m_rd_ready,
   input  logic [127:0]              m_rd_data,
   input  logic                      m_rd_data_valid,
   output logic [AXI_ADDR_WIDTH-1:0] m_wr_addr,
   output logic [127:0]              m_wr_data,
   output logic                      m_wr_valid,
   input  logic                      m_wr_ready,
   output logic [AXI_ADDR_WIDTH-1:0] m_desc_addr,
   output logic                      m_desc_valid,
   input  logic                      m_desc_ready,
   input  logic [LEN_WIDTH-1:0]      s_cpl_length,
   input  logic                      s_cpl_valid,
   output logic                      s_cpl_ready,
   output logic [INDEX_WIDTH-1:0]    ring_index,
   output logic                      busy,
   output logic [2:0]                state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_WAIT, S_CHECK, S_POLL, S_ISSUE, S_WAIT_CPL, S_WR
   } state_t;

   localparam int PCW = $clog2(POLL_INTERVAL) + 1;

   state_t                   state;
   logic [PCW-1:0]           poll_cnt;
   logic [127:0]             desc_q;
   logic [INDEX_WIDTH-1:0]   next_index;

   // The fetched length field is always overwritten on writeback.
   logic unused_desc_len;
   assign unused_desc_len = ^desc_q[95:64];

   assign state_dbg = state;

   // Base and size are sampled live. Software only changes them while idle.
   function automatic logic [AXI_ADDR_WIDTH-1:0] desc_addr(input logic [INDEX_WIDTH-1:0] idx);
      desc_addr = ring_base_addr + AXI_ADDR_WIDTH'({idx, 4'b0000});
   endfunction

   // Wrap at the last slot. An index beyond a shrunken ring (or a zero-size
   // ring) also wraps to 0.
   always_comb begin
      next_index = ring_index + INDEX_WIDTH'(1);
      if (ring_size == '0 || {1'b0, ring_index} >= ring_size - (INDEX_WIDTH+1)'(1))
         next_index = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         poll_cnt     <= '0;
         desc_q       <= '0;
         ring_index   <= '0;
         busy         <= 1'b0;
         m_rd_addr    <= '0;
         m_rd_valid   <= 1'b0;
         m_wr_addr    <= '0;
         m_wr_data    <= '0;
         m_wr_valid   <= 1'b0;
         m_desc_addr  <= '0;
         m_desc_valid <= 1'b0;
         s_cpl_ready  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (enable && ring_size != '0) begin
                  state      <= S_RD_REQ;
                  busy       <= 1'b1;
                  m_rd_valid <= 1'b1;
                  m_rd_addr  <= desc_addr(ring_index);
               end
            end
            S_RD_REQ: begin
               if (m_rd_ready) begin
                  m_rd_valid <= 1'b0;
                  state      <= S_RD_WAIT;
               end
            end
            S_RD_WAIT: begin
               if (m_rd_data_valid) begin
                  desc_q <= m_rd_data;
                  state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (desc_q[96]) begin
                  state        <= S_ISSUE;
                  m_desc_valid <= 1'b1;
                  m_desc_addr  <= desc_q[AXI_ADDR_WIDTH-1:0];
               end else if (!enable) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (POLL_INTERVAL == 1) begin
                  // A one-cycle interval leaves no room for a POLL cycle.
                  state      <= S_RD_REQ;
                  m_rd_valid <= 1'b1;
                  m_rd_addr  <= desc_addr(ring_index);
               end else begin
                  // The CHECK cycle counts as cycle 0 of the interval. POLL then
                  // spans cycles 1..POLL_INTERVAL-1, so the re-read request
                  // rises exactly POLL_INTERVAL cycles after CHECK.
                  state    <= S_POLL;
                  poll_cnt <= PCW'(1);
               end
            end
            S_POLL: begin
               if (!enable) begin
                  state    <= S_IDLE;
                  busy     <= 1'b0;
                  poll_cnt <= '0;
               end else if (poll_cnt == PCW'(POLL_INTERVAL - 1)) begin
                  state      <= S_RD_REQ;
                  poll_cnt   <= '0;
                  m_rd_valid <= 1'b1;
                  m_rd_addr  <= desc_addr(ring_index);
               end else begin
                  poll_cnt <= poll_cnt + PCW'(1);
               end
            end
            S_ISSUE: begin
               // Once a buffer is handed out, the descriptor is finished
               // through writeback regardless of enable.
               if (m_desc_ready) begin
                  m_desc_valid <= 1'b0;
                  s_cpl_ready  <= 1'b1;
                  state        <= S_WAIT_CPL;
               end
            end
            S_WAIT_CPL: begin
               if (s_cpl_valid) begin
                  s_cpl_ready <= 1'b0;
                  m_wr_valid  <= 1'b1;
                  m_wr_addr   <= desc_addr(ring_index);
                  m_wr_data   <= {desc_q[127:97], 1'b0, 32'(s_cpl_length), desc_q[63:0]};
                  state       <= S_WR;
               end
            end
            S_WR: begin
               if (m_wr_ready) begin
                  m_wr_valid <= 1'b0;
                  ring_index <= next_index;
                  if (enable && ring_size != '0) begin
                     state      <= S_RD_REQ;
                     m_rd_valid <= 1'b1;
                     m_rd_addr  <= desc_addr(next_index);
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_desc_ring_ctrl.sv
// Directed testbench for dma_desc_ring_ctrl. The bench plays the memory
// system, the DMA write engine and software. It steps through the scenarios
// in order, and checks every output against hand-derived expected values.
module tb_dma_desc_ring_ctrl;

   localparam int AW = 32;
   localparam int LW = 16;
   localparam int IW = 8;
   localparam int PI = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           enable = 1'b0;
   logic [AW-1:0]  ring_base_addr = '0;
   logic [IW:0]    ring_size = '0;
   logic [AW-1:0]  m_rd_addr;
   logic           m_rd_valid;
   logic           m_rd_ready = 1'b0;
   logic [127:0]   m_rd_data = '0;
   logic           m_rd_data_valid = 1'b0;
   logic [AW-1:0]  m_wr_addr;
   logic [127:0]   m_wr_data;
   logic           m_wr_valid;
   logic           m_wr_ready = 1'b0;
   logic [AW-1:0]  m_desc_addr;
   logic           m_desc_valid;
   logic           m_desc_ready = 1'b0;
   logic [LW-1:0]  s_cpl_length = '0;
   logic           s_cpl_valid = 1'b0;
   logic           s_cpl_ready;
   logic [IW-1:0]  ring_index;
   logic           busy;
   logic [2:0]     state_dbg;

   int checks = 0;
   int failures = 0;

   dma_desc_ring_ctrl #(
      .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .INDEX_WIDTH(IW), .POLL_INTERVAL(PI)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .ring_base_addr(ring_base_addr), .ring_size(ring_size),
      .m_rd_addr(m_rd_addr), .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready),
      .m_rd_data(m_rd_data), .m_rd_data_valid(m_rd_data_valid),
      .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_valid(m_wr_valid),
      .m_wr_ready(m_wr_ready),
      .m_desc_addr(m_desc_addr), .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
      .s_cpl_length(s_cpl_length), .s_cpl_valid(s_cpl_valid), .s_cpl_ready(s_cpl_ready),
      .ring_index(ring_index), .busy(busy), .state_dbg(state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   // Advance to just after the next rising edge; outputs are sampled and
   // inputs driven here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Ring descriptor i: buffer address 0xA000 + 0x800*i, recognisable
   // reserved and upper-address bits, and a junk length that must be replaced.
   function automatic logic [127:0] desc_of(input int i, input logic empty);
      logic [127:0] d;
      d[127:97] = 31'h2A00_0000 + 31'(i);
      d[96]     = empty;
      d[95:64]  = 32'hFFFF_0000 + 32'(i);
      d[63:32]  = 32'hC0DE_0000 + 32'(i);
      d[31:0]   = 32'hA000 + 32'h800 * 32'(i);
      return d;
   endfunction

   function automatic logic [127:0] wb_of(input int i, input logic [LW-1:0] len);
      logic [127:0] d;
      d        = desc_of(i, 1'b1);
      d[96]    = 1'b0;
      d[95:64] = {16'h0000, len};
      return d;
   endfunction

   // ---------------- driver tasks ----------------
   // Serve one descriptor read. Returns in the CHECK cycle.
   task automatic do_read(input logic [AW-1:0] exp_addr, input logic [127:0] data, input int stall);
      int n = 0;
      while (!m_rd_valid && n < 200) begin
         tick();
         n++;
      end
      check("rd_valid_seen", m_rd_valid, 1);
      check("rd_addr", m_rd_addr, exp_addr);
      for (int s = 0; s < stall; s++) begin
         // A stray response strobe before acceptance must be ignored.
         m_rd_data       = '1;
         m_rd_data_valid = 1'b1;
         tick();
         check("rd_hold_valid", m_rd_valid, 1);
         check("rd_hold_addr", m_rd_addr, exp_addr);
      end
      m_rd_data_valid = 1'b0;
      m_rd_ready      = 1'b1;
      tick();
      m_rd_ready = 1'b0;
      check("rd_valid_drop", m_rd_valid, 0);
      m_rd_data       = data;
      m_rd_data_valid = 1'b1;
      tick();
      m_rd_data_valid = 1'b0;
      m_rd_data       = '0;
   endtask

   // Entered in the CHECK cycle. Returns in the first WAIT_CPL cycle.
   task automatic do_issue(input logic [AW-1:0] exp_buf, input int stall);
      check("desc_not_in_check", m_desc_valid, 0);
      tick();
      check("desc_valid_latency", m_desc_valid, 1);
      check("desc_addr", m_desc_addr, exp_buf);
      for (int s = 0; s < stall; s++) begin
         // An early completion must be ignored.
         s_cpl_length = 16'hDEAD;
         s_cpl_valid  = 1'b1;
         tick();
         check("desc_hold_valid", m_desc_valid, 1);
         check("desc_hold_addr", m_desc_addr, exp_buf);
         check("cpl_ready_early", s_cpl_ready, 0);
      end
      s_cpl_valid  = 1'b0;
      m_desc_ready = 1'b1;
      tick();
      m_desc_ready = 1'b0;
      check("desc_valid_drop", m_desc_valid, 0);
      check("cpl_ready_up", s_cpl_ready, 1);
      check("wr_not_early", m_wr_valid, 0);
   endtask

   // Entered in WAIT_CPL. Returns in the first WR cycle.
   task automatic do_cpl(input logic [LW-1:0] len);
      s_cpl_length = len;
      s_cpl_valid  = 1'b1;
      tick();
      s_cpl_valid = 1'b0;
      check("cpl_ready_drop", s_cpl_ready, 0);
      check("wr_valid_latency", m_wr_valid, 1);
   endtask

   // Entered in the WR cycle. Returns in the cycle after the handshake.
   task automatic do_wr(input logic [AW-1:0] exp_addr, input logic [127:0] exp_data, input int stall);
      check("wr_valid", m_wr_valid, 1);
      check("wr_addr", m_wr_addr, exp_addr);
      check("wr_data", m_wr_data, exp_data);
      for (int s = 0; s < stall; s++) begin
         tick();
         check("wr_hold_valid", m_wr_valid, 1);
         check("wr_hold_addr", m_wr_addr, exp_addr);
         check("wr_hold_data", m_wr_data, exp_data);
      end
      m_wr_ready = 1'b1;
      tick();
      m_wr_ready = 1'b0;
      check("wr_valid_drop", m_wr_valid, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int idx;

      // Reset values
      tick(); tick(); tick();
      check("rst_rd_valid", m_rd_valid, 0);
      check("rst_wr_valid", m_wr_valid, 0);
      check("rst_desc_valid", m_desc_valid, 0);
      check("rst_cpl_ready", s_cpl_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_index", ring_index, 0);
      check("rst_rd_addr", m_rd_addr, 0);
      check("rst_wr_data", m_wr_data, 0);
      rst = 1'b0;
      tick();
      check("idle_no_enable", busy, 0);

      // Scenario 1: four-entry ring at 0x1000, every descriptor available
      ring_base_addr = 32'h1000;
      ring_size      = 9'd4;
      enable         = 1'b1;
      tick();
      check("start_rd_valid", m_rd_valid, 1);
      check("start_busy", busy, 1);
      for (int i = 0; i < 4; i++) begin
         check("s1_index", ring_index, IW'(i));
         do_read(32'h1000 + 32'(16 * i), desc_of(i, 1'b1), 0);
         do_issue(32'hA000 + 32'h800 * 32'(i), 0);
         do_cpl(LW'(60 + i));
         do_wr(32'h1000 + 32'(16 * i), wb_of(i, LW'(60 + i)), 0);
         check("s1_next_index", ring_index, IW'((i + 1) % 4));
         check("s1_next_rd", m_rd_valid, 1);
      end

      // Scenario 2: unavailable descriptor is polled and re-read after PI cycles
      do_read(32'h1000, desc_of(0, 1'b0), 0);
      for (int k = 1; k < PI; k++) begin
         tick();
         check("poll_rd_quiet", m_rd_valid, 0);
         check("poll_desc_quiet", m_desc_valid, 0);
      end
      tick();
      check("poll_reread", m_rd_valid, 1);
      check("poll_reread_addr", m_rd_addr, 32'h1000);
      check("poll_index", ring_index, 0);
      do_read(32'h1000, desc_of(0, 1'b1), 0);
      do_issue(32'hA000, 0);
      do_cpl(16'd60);
      do_wr(32'h1000, wb_of(0, 16'd60), 0);
      check("s2_index", ring_index, 1);

      // Scenario 3: random stalls on every request channel
      for (int j = 0; j < 4; j++) begin
         idx = (1 + j) % 4;
         do_read(32'h1000 + 32'(16 * idx), desc_of(idx, 1'b1), int'($urandom_range(0, 5)));
         do_issue(32'hA000 + 32'h800 * 32'(idx), int'($urandom_range(0, 5)));
         do_cpl(LW'(60 + idx));
         do_wr(32'h1000 + 32'(16 * idx), wb_of(idx, LW'(60 + idx)), int'($urandom_range(0, 5)));
         check("s3_next_index", ring_index, IW'((idx + 1) % 4));
      end

      // Scenario 4: enable drops while waiting for the completion
      do_read(32'h1010, desc_of(1, 1'b1), 0);
      do_issue(32'hA800, 0);
      enable = 1'b0;
      tick();
      check("s4_cpl_still_ready", s_cpl_ready, 1);
      do_cpl(16'd100);
      do_wr(32'h1010, wb_of(1, 16'd100), 0);
      check("s4_busy", busy, 0);
      check("s4_rd_valid", m_rd_valid, 0);
      check("s4_index", ring_index, 2);
      tick(); tick();
      check("s4_stays_idle", m_rd_valid, 0);

      // Scenario 5: reset in WR while the writeback is stalled
      enable = 1'b1;
      tick();
      check("s5_rd_valid", m_rd_valid, 1);
      do_read(32'h1020, desc_of(2, 1'b1), 0);
      do_issue(32'hB000, 0);
      do_cpl(16'd7);
      tick();
      check("s5_wr_pending", m_wr_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("s5_rst_wr_valid", m_wr_valid, 0);
      check("s5_rst_rd_valid", m_rd_valid, 0);
      check("s5_rst_desc_valid", m_desc_valid, 0);
      check("s5_rst_cpl_ready", s_cpl_ready, 0);
      check("s5_rst_busy", busy, 0);
      check("s5_rst_index", ring_index, 0);
      check("s5_rst_wr_addr", m_wr_addr, 0);
      check("s5_rst_wr_data", m_wr_data, 0);
      tick();
      check("s5_restart_rd", m_rd_valid, 1);
      check("s5_restart_addr", m_rd_addr, 32'h1000);
      // Unavailable descriptor with enable low: CHECK goes straight to IDLE.
      enable = 1'b0;
      do_read(32'h1000, desc_of(0, 1'b0), 0);
      tick();
      check("s5_check_idle_busy", busy, 0);
      check("s5_check_idle_index", ring_index, 0);
      tick(); tick();
      check("s5_no_poll", m_rd_valid, 0);

      // Scenario 6: single-entry ring
      ring_base_addr = 32'h2000;
      ring_size      = 9'd1;
      enable         = 1'b1;
      tick();
      check("s6_rd_valid", m_rd_valid, 1);
      for (int r = 0; r < 2; r++) begin
         check("s6_index", ring_index, 0);
         do_read(32'h2000, desc_of(r, 1'b1), 0);
         do_issue(32'hA000 + 32'h800 * 32'(r), 0);
         do_cpl(LW'(200 + r));
         do_wr(32'h2000, wb_of(r, LW'(200 + r)), 0);
         check("s6_next_index", ring_index, 0);
         check("s6_next_rd", m_rd_valid, 1);
      end
      enable = 1'b0;
      do_read(32'h2000, desc_of(0, 1'b0), 0);
      tick();
      check("s6_idle", busy, 0);

      // Scenario 7: zero-size ring never leaves IDLE
      ring_size = 9'd0;
      enable    = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("s7_busy", busy, 0);
         check("s7_rd_valid", m_rd_valid, 0);
      end
      enable = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dma_desc_ring_ctrl.md
# dma_desc_ring_ctrl

Descriptor ring controller for the packet-capture DMA path. It fetches 128-bit descriptors from a ring in host memory, hands each available buffer address to the DMA write engine, and collects the completed packet length. It then writes the descriptor back with the length filled in and the empty flag cleared, and advances around the ring. It is the memory-side initiator that produces and consumes the descriptor words held by the descriptor register stage.

## Interface
- AXI_ADDR_WIDTH, 32: width of memory and buffer addresses (≤ 64).
- LEN_WIDTH, 16: width of the packet length field (≤ 32).
- INDEX_WIDTH, 8: width of the ring index; maximum ring size is 2^INDEX_WIDTH.
- POLL_INTERVAL, 64: idle cycles between re-reads of a descriptor that is not available (≥ 1).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  ring processing enable.
- ring_base_addr  in  AXI_ADDR_WIDTH  byte address of descriptor 0; must be 16-byte aligned.
- ring_size  in  INDEX_WIDTH+1  number of descriptors in the ring; 0 = ring disabled.
- m_rd_addr  out  AXI_ADDR_WIDTH  descriptor read address.
- m_rd_valid  out  1  read request valid.
- m_rd_ready  in  1  read request accepted.
- m_rd_data  in  128  read response data.
- m_rd_data_valid  in  1  read response strobe (single cycle, no backpressure).
- m_wr_addr  out  AXI_ADDR_WIDTH  writeback address.
- m_wr_data  out  128  writeback descriptor.
- m_wr_valid  out  1  writeback valid.
- m_wr_ready  in  1  writeback accepted.
- m_desc_addr  out  AXI_ADDR_WIDTH  buffer address for the DMA write engine.
- m_desc_valid  out  1  buffer address valid.
- m_desc_ready  in  1  buffer address accepted.
- s_cpl_length  in  LEN_WIDTH  bytes written to the buffer.
- s_cpl_valid  in  1  completion valid.
- s_cpl_ready  out  1  completion accepted.
- ring_index  out  INDEX_WIDTH  current descriptor index.
- busy  out  1  high in every state except IDLE.

## Operation
- Descriptor layout: [AXI_ADDR_WIDTH-1:0] = buffer address; [95:64] = length; [96] = empty flag (1 = buffer available to hardware); [127:97] = reserved.
- Descriptor address = ring_base_addr + ring_index × 16. Arithmetic is modulo 2^AXI_ADDR_WIDTH.
- States and transitions:
  - IDLE: go to RD_REQ when enable = 1 and ring_size ≠ 0.
  - RD_REQ: m_rd_valid = 1; go to RD_WAIT on m_rd_ready.
  - RD_WAIT: latch m_rd_data into the descriptor register on m_rd_data_valid, then go to CHECK.
  - CHECK: if bit 96 = 1, go to ISSUE. Otherwise, if enable = 0 go to IDLE, else go to POLL.
  - POLL: count POLL_INTERVAL cycles; go to IDLE if enable drops, else go to RD_REQ at the end of the count.
  - ISSUE: m_desc_valid = 1; go to WAIT_CPL on m_desc_ready.
  - WAIT_CPL: s_cpl_ready = 1; on s_cpl_valid, latch the length and go to WR.
  - WR: m_wr_valid = 1; on m_wr_ready, advance the index and go to RD_REQ if enable = 1 and ring_size ≠ 0, else go to IDLE.
- Writeback data:
  - bits [127:97] and [63:0] unchanged from the fetched descriptor;
  - [96] = 0;
  - [95:64] = s_cpl_length zero-extended to 32 bits.
- Index advance: if ring_index = ring_size − 1 (or ring_size − 1 < ring_index), the index becomes 0; otherwise it increments by 1.
- Deasserting enable never aborts a descriptor once ISSUE has been entered. The ring finishes through WR, then idles. The index is retained across enable cycles.
- ring_base_addr and ring_size are sampled on every address computation. Software changes them only while busy = 0.
- s_cpl_valid outside WAIT_CPL is ignored (s_cpl_ready = 0).

## Timing
- Reset values: all valids = 0, s_cpl_ready = 0, busy = 0, ring_index = 0, all address and data outputs = 0, state = IDLE, poll counter = 0.
- All outputs are registered. Valids stay high with stable payload until the handshake; the valid drops in the cycle after the handshake.
- IDLE to m_rd_valid: 1 cycle after enable is sampled high.
- m_rd_data_valid to m_desc_valid: 2 cycles (latch, then CHECK).
- s_cpl_valid handshake to m_wr_valid: 1 cycle.
- m_wr_ready handshake to the next m_rd_valid: 1 cycle; ring_index updates on the same edge.
- Poll gap: exactly POLL_INTERVAL cycles between the CHECK cycle and the next m_rd_valid.
- m_rd_data_valid outside RD_WAIT is ignored.
- Reset mid-operation: rst in any state returns everything to reset values on the next edge. Outstanding transactions are dropped.

## Test plan
- Ring base 0x1000, size 4, all descriptors with empty = 1 and buffer addresses 0xA000 + 0x800·i; completions of 60, 61, 62, 63 → reads at 0x1000, 0x1010, 0x1020, 0x1030, then 0x1000 again. Writebacks carry length 60..63 in [95:64], bit 96 = 0, address bits unchanged; ring_index sequence 0, 1, 2, 3, 0.
- Descriptor with empty = 0, POLL_INTERVAL = 4 → no m_desc_valid; re-read at the same address exactly 4 cycles after CHECK. Setting empty = 1 in the model → issue proceeds.
- Random stalls on m_rd_ready, m_desc_ready and m_wr_ready (0–5 cycles) → payloads stable while valid; exactly one handshake per transaction; same results as the first scenario.
- enable dropped while in WAIT_CPL → completion length 100 is still written back, then IDLE with busy = 0 and ring_index advanced by 1.
- ring_size = 1 → every access goes to ring_base_addr and ring_index stays 0. ring_size = 0 → block stays in IDLE with enable = 1.
- rst asserted in WR with m_wr_ready = 0 → next cycle all valids = 0, ring_index = 0, busy = 0; after rst the fetch restarts at ring_base_addr.
